adder_2in_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one adder_2in instance among NREQ requesters
//  in the hadamard stage. Each request carries two sign-magnitude operands.
//  The block arbitrates, registers the winning pair and returns the two's-complement sum

---
 rtl/adder_2in_rr_sched.sv | 157 +++++++++++++++
 tb/tb_adder_2in_rr_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_2in_rr_sched.sv
// Round-robin scheduler that shares one two-operand sign-magnitude adder among
// NREQ requesters. Stage 1 holds the granted operand pair, stage 2 holds the
// two's-complement sum and its owner ID. Both stages use valid/ready flow control.

// Adds two sign-magnitude operands and returns the two's-complement sum, modulo 2^W.
module adder_2in #(
   parameter int sigWidth   = 4,
   parameter int low_expand = 2,
   localparam int W         = sigWidth + 4 + low_expand
) (
   input  logic [W-1:0] i_op_a,
   input  logic [W-1:0] i_op_b,
   output logic [W-1:0] o_sum
);

   logic [W-1:0] w_mag_a;
   logic [W-1:0] w_mag_b;
   logic [W-1:0] w_tc_a;
   logic [W-1:0] w_tc_b;

   // Convert each operand to two's complement, then add. The carry out is dropped.
   always_comb begin
      w_mag_a = {1'b0, i_op_a[W-2:0]};
      w_mag_b = {1'b0, i_op_b[W-2:0]};
      w_tc_a  = i_op_a[W-1] ? (~w_mag_a + W'(1)) : w_mag_a;
      w_tc_b  = i_op_b[W-1] ? (~w_mag_b + W'(1)) : w_mag_b;
      o_sum   = w_tc_a + w_tc_b;
   end

endmodule

module adder_2in_rr_sched #(
   parameter int sigWidth   = 4,
   parameter int low_expand = 2,
   parameter int NREQ       = 4,
   localparam int W         = sigWidth + 4 + low_expand,
   localparam int IDW       = (NREQ > 2) ? $clog2(NREQ) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*2*W-1:0] req_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [W-1:0]        out_sum,
   output logic [IDW-1:0]      out_id,
   output logic                busy
);

   // Pipeline state
   logic           r_s1_valid;
   logic [W-1:0]   r_s1_a;
   logic [W-1:0]   r_s1_b;
   logic [IDW-1:0] r_s1_id;
   logic           r_s2_valid;
   logic [W-1:0]   r_sum;
   logic [IDW-1:0] r_id;
   logic [IDW-1:0] r_rr_ptr;

   // Flow control and arbitration
   logic           w_s2_free;
   logic           w_s1_adv;
   logic           w_s1_free;
   logic           w_found;
   logic           w_gnt_any;
   logic [IDW-1:0] w_gnt_idx;
   logic [W-1:0]   w_sel_a;
   logic [W-1:0]   w_sel_b;
   logic [W-1:0]   w_add_sum;
   int             w_idx;

   // Stall chain: a stage may load when it is empty or is emptying this cycle.
   always_comb begin
      w_s2_free = !r_s2_valid || out_ready;
      w_s1_adv  = r_s1_valid && w_s2_free;
      w_s1_free = !r_s1_valid || w_s1_adv;
   end

   // Round-robin search: first valid requester at or above r_rr_ptr, wrapping to 0.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      w_found   = 1'b0;
      w_gnt_idx = '0;
      w_idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = int'(r_rr_ptr) + k;
         if (w_idx >= NREQ) w_idx = w_idx - NREQ;
         if (!w_found && req_valid[w_idx]) begin
            w_found   = 1'b1;
            w_gnt_idx = IDW'(w_idx);
         end
      end
      w_gnt_any = w_found && w_s1_free && !rst;
      req_ready = '0;
      if (w_gnt_any) req_ready[w_gnt_idx] = 1'b1;
   end

   // Pick the granted operand pair; a negative zero is folded to all-zero.
   always_comb begin
      w_sel_a = req_data[int'(w_gnt_idx)*2*W +: W];
      w_sel_b = req_data[int'(w_gnt_idx)*2*W + W +: W];
      if (w_sel_a[W-2:0] == '0) w_sel_a = '0;
      if (w_sel_b[W-2:0] == '0) w_sel_b = '0;
   end

   // The single shared adder sits between stage 1 and stage 2.
   adder_2in #(
      .sigWidth   (sigWidth),
      .low_expand (low_expand)
   ) u_adder (
      .i_op_a (r_s1_a),
      .i_op_b (r_s1_b),
      .o_sum  (w_add_sum)
   );

   // Control state: stage valid flags and the round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_rr_ptr   <= '0;
      end else begin
         if (w_s1_free) r_s1_valid <= w_gnt_any;
         if (w_s2_free) r_s2_valid <= r_s1_valid;
         if (w_gnt_any) r_rr_ptr <= (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + IDW'(1);
      end
   end

   // Stage 1 payload is only meaningful while r_s1_valid is set.
   always_ff @(posedge clk) begin
      // NOTE: datapath registers guarded by a valid flag need no reset; only the flag does.
      if (w_gnt_any) begin
         r_s1_a  <= w_sel_a;
         r_s1_b  <= w_sel_b;
         r_s1_id <= w_gnt_idx;
      end
   end

   // Stage 2 result registers; they hold while the downstream stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum <= '0;
         r_id  <= '0;
      end else if (w_s1_adv) begin
         r_sum <= w_add_sum;
         r_id  <= r_s1_id;
      end
   end

   assign out_valid = r_s2_valid;
   assign out_sum   = r_sum;
   assign out_id    = r_id;
   assign busy      = r_s1_valid || r_s2_valid;

endmodule

// File: tb/tb_adder_2in_rr_sched.sv
// Self-checking bench for adder_2in_rr_sched: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a queue-based reference model.
module tb_adder_2in_rr_sched;

   localparam int NREQ = 4;
   localparam int W    = 10;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*2*W-1:0] req_data;
   logic                out_valid;
   logic                out_ready;
   logic [W-1:0]        out_sum;
   logic [IDW-1:0]      out_id;
   logic                busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   adder_2in_rr_sched #(.sigWidth(4), .low_expand(2), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_id    (out_id),
      .busy      (busy)
   );

   // Reference model: ordered list of in-flight results; 'vis' marks the one at the output.
   typedef struct {
      logic [W-1:0] sum;
      int           id;
      bit           vis;
   } item_t;

   item_t m_q[$];
   int    m_rr;
   int    last_grant;
   int    seen_ids[$];

   typedef struct {
      int           id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Signed value of a sign-magnitude operand, then wrap to W bits.
   function automatic logic [W-1:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b);
      int va;
      int vb;
      va = a[W-1] ? -int'(a[W-2:0]) : int'(a[W-2:0]);
      vb = b[W-1] ? -int'(b[W-2:0]) : int'(b[W-2:0]);
      return W'(va + vb);
   endfunction

   function automatic int m_grant(input logic [NREQ-1:0] v, input logic ordy);
      bit has_front;
      bit has_back;
      has_front = (m_q.size() > 0) && m_q[0].vis;
      has_back  = (m_q.size() > 0) && !m_q[m_q.size()-1].vis;
      if (has_back && has_front && !ordy) return -1;
      for (int k = 0; k < NREQ; k++)
         if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
      return -1;
   endfunction

   task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
      req_data[id*2*W +: 2*W] = {b, a};
   endtask

   function automatic logic [W-1:0] rand_op();
      case ($urandom_range(0, 7))
         0:       return 10'h200;
         1:       return 10'h1FF;
         2:       return 10'h3FF;
         default: return W'($urandom);
      endcase
   endfunction

   // One clock cycle: inputs already driven at the falling edge.
   task automatic cycle();
      int              g;
      logic [NREQ-1:0] exp_rdy;
      bit              exp_vis;
      #1;
      g       = m_grant(req_valid, out_ready);
      exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
      exp_vis = (m_q.size() > 0) && m_q[0].vis;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(exp_vis));
      check("busy", 32'(busy), 32'(m_q.size() > 0));
      if (exp_vis) begin
         check("out_sum", 32'(out_sum), 32'(m_q[0].sum));
         check("out_id", 32'(out_id), 32'(m_q[0].id));
      end
      if (out_valid && out_ready) seen_ids.push_back(int'(out_id));
      last_grant = g;
      @(posedge clk);
      if (exp_vis && out_ready) void'(m_q.pop_front());
      if (m_q.size() > 0 && !m_q[0].vis) m_q[0].vis = 1'b1;
      if (g >= 0) begin
         m_q.push_back('{sum: ref_sum(req_data[g*2*W +: W], req_data[g*2*W+W +: W]), id: g, vis: 1'b0});
         m_rr = (g + 1) % NREQ;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '1;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'(0));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_out_sum", 32'(out_sum), 32'(0));
      check("rst_out_id", 32'(out_id), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = '0;
      m_q.delete();
      m_rr = 0;
   endtask

   vec_t vecs[8];
   logic [W-1:0] held;

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      out_ready = 1'b0;
      m_rr      = 0;
      @(negedge clk);
      do_reset();

      // Single-request vectors: result visible two cycles after acceptance.
      vecs[0] = '{0, 10'h005, 10'h203, 10'h002};
      vecs[1] = '{1, 10'h200, 10'h000, 10'h000};
      vecs[2] = '{2, 10'h1FF, 10'h001, 10'h200};
      vecs[3] = '{3, 10'h3FF, 10'h3FF, 10'h002};
      vecs[4] = '{1, 10'h005, 10'h207, 10'h3FE};
      vecs[5] = '{0, 10'h000, 10'h200, 10'h000};
      vecs[6] = '{2, 10'h100, 10'h100, 10'h200};
      vecs[7] = '{3, 10'h20A, 10'h003, 10'h3F9};
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_req(vecs[i].id, vecs[i].a, vecs[i].b);
         req_valid = NREQ'(1 << vecs[i].id);
         cycle();
         req_valid = '0;
         cycle();
         #1;
         check("vec_valid", 32'(out_valid), 32'(1));
         check("vec_sum", 32'(out_sum), 32'(vecs[i].exp));
         check("vec_id", 32'(out_id), 32'(vecs[i].id));
         cycle();
      end

      // Fairness: all requesters held valid, grants rotate from 0.
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, rand_op(), rand_op());
      req_valid = '1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle();
         check("fair_grant", 32'(last_grant), 32'(i % NREQ));
      end
      req_valid = '0;
      repeat (3) cycle();

      // Backpressure: three requests, output stalled for five cycles.
      out_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, rand_op(), rand_op());
      req_valid = 4'b0111;
      for (int i = 0; i < 5; i++) begin
         if (i >= 2) begin
            #1;
            check("bp_ready", 32'(req_ready), 32'(0));
            if (i == 2) begin
               held = out_sum;
               check("bp_sum0", 32'(held), 32'(ref_sum(req_data[W-1:0], req_data[2*W-1:W])));
            end else begin
               check("bp_stable", 32'(out_sum), 32'(held));
            end
         end
         cycle();
         if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      end
      seen_ids.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      end
      check("bp_drain_cnt", 32'(seen_ids.size()), 32'(3));
      for (int i = 0; i < 3 && i < seen_ids.size(); i++)
         check("bp_drain_id", 32'(seen_ids[i]), 32'(i));

      // Reset with both stages full flushes the pipeline.
      out_ready = 1'b0;
      req_valid = 4'b1100;
      cycle();
      cycle();
      #1;
      check("full_valid", 32'(out_valid), 32'(1));
      check("full_ready", 32'(req_ready), 32'(0));
      do_reset();
      req_valid = 4'b1010;
      out_ready = 1'b1;
      cycle();
      check("post_rst_grant", 32'(last_grant), 32'(1));
      req_valid = '0;
      repeat (3) cycle();

      // Randomized traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) set_req(i, rand_op(), rand_op());
         req_valid = NREQ'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      req_valid = '0;
      out_ready = 1'b1;
      repeat (4) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
